// File: rtl/cordic_rotate_iter_if.sv
// cordic_rotate_iter_if
// Groups the request, arctan-table and result signals of the iterative
// CORDIC rotator.
//   start               request a new rotation
//   x_in, y_in, z_in    initial vector and target angle (256 LSB/degree)
//   iter_idx            index presented to the external arctan table
//   alpha_i             arctan(2^-iter_idx) returned by the table
//   x_out, y_out, z_res rotated vector (gain K not removed) and residual angle
//   busy, done          rotation in progress / one-cycle result-valid pulse
// master: the requester and table side; slave: the rotator.
interface cordic_rotate_iter_if;
   logic               start;
   logic signed [15:0] x_in;
   logic signed [15:0] y_in;
   logic signed [15:0] z_in;
   logic        [3:0]  iter_idx;
   logic signed [15:0] alpha_i;
   logic signed [15:0] x_out;
   logic signed [15:0] y_out;
   logic signed [15:0] z_res;
   logic               busy;
   logic               done;

   modport master (
      output start, x_in, y_in, z_in, alpha_i,
      input  iter_idx, x_out, y_out, z_res, busy, done
   );

   modport slave (
      input  start, x_in, y_in, z_in, alpha_i,
      output iter_idx, x_out, y_out, z_res, busy, done
   );
endinterface

// File: rtl/cordic_rotate_iter.sv
// cordic_rotate_iter
// Iterative CORDIC in rotation mode: one micro-rotation per clock, ITER
// clocks per job. The arctan constants come from an external table that is
// addressed by iter_idx and read combinationally through alpha_i.
// Ports:
//   clk    sole clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    cordic_rotate_iter_if.slave (start, x_in, y_in, z_in, alpha_i in;
//          iter_idx, x_out, y_out, z_res, busy, done out)
// Parameter ITER: number of micro-rotations, legal range 1..16.
//
// state  | meaning
// IDLE   | waiting for start; iter_idx held at 0
// ROTATE | one micro-rotation per edge, iter_idx = current iteration
module cordic_rotate_iter #(
   parameter int ITER = 16
) (
   input logic                 clk,
   input logic                 rst_n,
   cordic_rotate_iter_if.slave bus
);

   typedef enum logic {
      IDLE,
      ROTATE
   } state_t;

   localparam logic [3:0] LAST_IDX = 4'(ITER - 1);

   state_t             state;
   state_t             state_nxt;
   logic               load;
   logic               step;
   logic               finish;

   logic signed [17:0] x_r;
   logic signed [17:0] y_r;
   logic signed [15:0] z_r;
   logic        [3:0]  iter_r;
   logic               busy_r;
   logic               done_r;
   logic signed [15:0] x_out_r;
   logic signed [15:0] y_out_r;
   logic signed [15:0] z_res_r;

   logic signed [17:0] x_sh;
   logic signed [17:0] y_sh;
   logic signed [17:0] x_nx;
   logic signed [17:0] y_nx;
   logic signed [15:0] z_nx;
   logic               z_pos;

   // Clamp the 18-bit datapath into the 16-bit output range; the gain K
   // lets the internal vector exceed 16 bits for large inputs.
   function automatic logic signed [15:0] sat16(input logic signed [17:0] v);
      if (v > 18'sd32767) begin
         return 16'sh7fff;
      end else if (v < -18'sd32768) begin
         return 16'sh8000;
      end else begin
         return v[15:0];
      end
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      step      = 1'b0;
      finish    = 1'b0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               load      = 1'b1;
               state_nxt = ROTATE;
            end
         end
         ROTATE: begin
            step = 1'b1;
            if (iter_r == LAST_IDX) begin
               finish    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Rotation direction follows the sign of the remaining angle; z = 0
   // rotates positively.
   assign z_pos = ~z_r[15];
   assign x_sh  = x_r >>> iter_r;
   assign y_sh  = y_r >>> iter_r;
   assign x_nx  = z_pos ? (x_r - y_sh) : (x_r + y_sh);
   assign y_nx  = z_pos ? (y_r + x_sh) : (y_r - x_sh);
   assign z_nx  = z_pos ? (z_r - bus.alpha_i) : (z_r + bus.alpha_i);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_r     <= '0;
         y_r     <= '0;
         z_r     <= '0;
         iter_r  <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         x_out_r <= '0;
         y_out_r <= '0;
         z_res_r <= '0;
      end else begin
         done_r <= 1'b0;
         if (load) begin
            x_r    <= {{2{bus.x_in[15]}}, bus.x_in};
            y_r    <= {{2{bus.y_in[15]}}, bus.y_in};
            z_r    <= bus.z_in;
            iter_r <= '0;
            busy_r <= 1'b1;
         end else if (step) begin
            x_r <= x_nx;
            y_r <= y_nx;
            z_r <= z_nx;
            if (finish) begin
               iter_r  <= '0;
               busy_r  <= 1'b0;
               done_r  <= 1'b1;
               x_out_r <= sat16(x_nx);
               y_out_r <= sat16(y_nx);
               z_res_r <= z_nx;
            end else begin
               iter_r <= iter_r + 4'd1;
            end
         end
      end
   end

   assign bus.iter_idx = iter_r;
   assign bus.busy     = busy_r;
   assign bus.done     = done_r;
   assign bus.x_out    = x_out_r;
   assign bus.y_out    = y_out_r;
   assign bus.z_res    = z_res_r;

endmodule

// File: tb/tb_cordic_rotate_iter.sv
// tb_cordic_rotate_iter
// Scoreboard bench for cordic_rotate_iter (ITER=16). Each accepted request
// pushes the expected result (integer reference model plus optional
// analytic targets with tolerance); a negedge monitor pops on every done.
module tb_cordic_rotate_iter;

   localparam int N_ITER = 16;

   typedef struct {
      int ex;
      int ey;
      int ez;
      int start_cyc;
      bit gold;
      int gx;
      int gy;
      int gtol;
      int gztol;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   n_checks;
   int   n_fail;
   bit   prev_done;
   exp_t sb_q[$];
   exp_t mon_e;

   int atan_tab[16] = '{11520, 6801, 3593, 1824, 916, 458, 229, 115,
                        57, 29, 14, 7, 4, 2, 1, 0};

   cordic_rotate_iter_if bus ();

   cordic_rotate_iter #(.ITER(N_ITER)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb bus.alpha_i = 16'(atan_tab[bus.iter_idx]);

   task automatic check_val(input string tag, input longint obs, input longint exp_v);
      n_checks++;
      if (obs !== exp_v) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic int clamp16(input int v);
      if (v > 32767) return 32767;
      if (v < -32768) return -32768;
      return v;
   endfunction

   function automatic int iabs(input int v);
      return (v < 0) ? -v : v;
   endfunction

   // Integer CORDIC reference: same rotation rule, plain int arithmetic.
   task automatic model(input int xi, input int yi, input int zi,
                        output int xo, output int yo, output int zo);
      int x, y, z, xn;
      x = xi;
      y = yi;
      z = zi;
      for (int i = 0; i < N_ITER; i++) begin
         if (z >= 0) begin
            xn = x - (y >>> i);
            y  = y + (x >>> i);
            z  = z - atan_tab[i];
         end else begin
            xn = x + (y >>> i);
            y  = y - (x >>> i);
            z  = z + atan_tab[i];
         end
         x = xn;
      end
      xo = clamp16(x);
      yo = clamp16(y);
      zo = z;
   endtask

   // Called at a negedge: drives an accepted request, records expectation,
   // then scrambles the inputs while the rotation runs.
   task automatic push_and_pulse(input int xi, input int yi, input int zi,
                                 input bit gold, input int gx, input int gy,
                                 input int gtol, input int gztol);
      exp_t e;
      model(xi, yi, zi, e.ex, e.ey, e.ez);
      e.start_cyc = cyc + 1;
      e.gold      = gold;
      e.gx        = gx;
      e.gy        = gy;
      e.gtol      = gtol;
      e.gztol     = gztol;
      sb_q.push_back(e);
      bus.x_in  = 16'(xi);
      bus.y_in  = 16'(yi);
      bus.z_in  = 16'(zi);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check_val("busy_after_start", bus.busy, 1);
      check_val("iter_after_start", bus.iter_idx, 0);
      bus.x_in = 16'($urandom);
      bus.y_in = 16'($urandom);
      bus.z_in = 16'($urandom);
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = 1'b0;
      for (int k = 0; k < budget && !seen; k++) begin
         @(negedge clk);
         if (bus.done) seen = 1'b1;
      end
      if (!seen) check_val("done_timeout", 0, 1);
   endtask

   always @(negedge clk) begin
      if (prev_done) check_val("done_width", bus.done, 0);
      prev_done = bus.done;
      if (bus.done) begin
         if (sb_q.size() == 0) begin
            check_val("spurious_done", bus.done, 0);
         end else begin
            mon_e = sb_q.pop_front();
            check_val("x_out", bus.x_out, mon_e.ex);
            check_val("y_out", bus.y_out, mon_e.ey);
            check_val("z_res", bus.z_res, mon_e.ez);
            check_val("latency", cyc - mon_e.start_cyc, N_ITER);
            check_val("busy_at_done", bus.busy, 0);
            check_val("iter_at_done", bus.iter_idx, 0);
            if (mon_e.gold) begin
               check_val($sformatf("gold_x(%0d vs %0d+-%0d)", bus.x_out, mon_e.gx, mon_e.gtol),
                         iabs(int'(bus.x_out) - mon_e.gx) <= mon_e.gtol, 1);
               check_val($sformatf("gold_y(%0d vs %0d+-%0d)", bus.y_out, mon_e.gy, mon_e.gtol),
                         iabs(int'(bus.y_out) - mon_e.gy) <= mon_e.gtol, 1);
               if (mon_e.gztol >= 0)
                  check_val($sformatf("gold_z(%0d within +-%0d)", bus.z_res, mon_e.gztol),
                            iabs(int'(bus.z_res)) <= mon_e.gztol, 1);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int xr, yr, zr;
      n_checks  = 0;
      n_fail    = 0;
      cyc       = 0;
      prev_done = 1'b0;
      rst_n     = 1'b0;
      bus.start = 1'b0;
      bus.x_in  = '0;
      bus.y_in  = '0;
      bus.z_in  = '0;
      #12;
      check_val("rst_busy", bus.busy, 0);
      check_val("rst_done", bus.done, 0);
      check_val("rst_iter", bus.iter_idx, 0);
      check_val("rst_x", bus.x_out, 0);
      check_val("rst_y", bus.y_out, 0);
      check_val("rst_z", bus.z_res, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      @(negedge clk);
      push_and_pulse(9949, 0, 0, 1'b1, 16384, 0, 4, 2);
      wait_done(40);
      @(negedge clk);
      push_and_pulse(9949, 0, 7680, 1'b1, 14189, 8192, 8, -1);
      wait_done(40);
      @(negedge clk);
      push_and_pulse(9949, 0, -23040, 1'b1, 0, -16384, 8, -1);
      wait_done(40);
      @(negedge clk);
      push_and_pulse(19000, 19000, 11520, 1'b1, 0, 32767, 8, -1);
      wait_done(40);

      for (int j = 0; j < 6; j++) begin
         xr = int'($urandom_range(0, 24000)) - 12000;
         yr = int'($urandom_range(0, 24000)) - 12000;
         zr = int'($urandom_range(0, 46080)) - 23040;
         @(negedge clk);
         push_and_pulse(xr, yr, zr, 1'b0, 0, 0, 0, -1);
         wait_done(40);
      end

      // start while busy is ignored; start on the done cycle is accepted
      @(negedge clk);
      push_and_pulse(5000, 3000, 2000, 1'b0, 0, 0, 0, -1);
      repeat (4) @(negedge clk);
      bus.x_in  = 16'(7000);
      bus.y_in  = -16'sd7000;
      bus.z_in  = -16'sd5000;
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      wait_done(40);
      push_and_pulse(-8000, 4000, 15000, 1'b0, 0, 0, 0, -1);
      wait_done(40);

      // reset in the middle of a rotation aborts it without done
      @(negedge clk);
      push_and_pulse(9949, 0, 0, 1'b1, 16384, 0, 4, 2);
      begin
         bit hit;
         hit = 1'b0;
         for (int k = 0; k < 20 && !hit; k++) begin
            if (bus.iter_idx == 4'd7) hit = 1'b1;
            else @(negedge clk);
         end
         check_val("reach_iter7", hit, 1);
      end
      #2;
      rst_n = 1'b0;
      #1;
      void'(sb_q.pop_back());
      check_val("abort_busy", bus.busy, 0);
      check_val("abort_done", bus.done, 0);
      check_val("abort_iter", bus.iter_idx, 0);
      check_val("abort_x", bus.x_out, 0);
      check_val("abort_y", bus.y_out, 0);
      check_val("abort_z", bus.z_res, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      push_and_pulse(9949, 0, 0, 1'b1, 16384, 0, 4, 2);
      wait_done(40);

      repeat (5) @(negedge clk);
      check_val("sb_empty", sb_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
